id_decode_pipe: RTL and testbench
=================================

# id_decode_pipe

Parametrised, elastic instruction-decode stage for the SSM core. Splits each fetched instruction word into opcode and two operand fields, flags opcodes outside the implemented set, and emits a one-hot opcode vector for the execute stage. Sits between fetch and execute, with valid/ready handshakes on both sides and a two-entry skid buffer, so a downstream stall never drops or duplicates an instruction.

## Interface
- INSTR_W, 16: instruction word width.
- OPC_W, 4: opcode width; the opcode is the top OPC_W bits of the instruction.
- NUM_OPS, 13: number of legal opcodes, 0..NUM_OPS-1; must be ≤ 2^OPC_W.
- PARAM_W is derived, not a parameter: (INSTR_W-OPC_W)/2. INSTR_W-OPC_W must be even.

Ports:
- ID_clock  in  1  sole clock, rising edge.
- ID_reset_n  in  1  asynchronous, active-low reset.
- ID_flush  in  1  drop all buffered instructions.
- ID_in_valid  in  1  fetch presents an instruction.
- ID_in_ready  out  1  decode can accept; registered.
- ID_instruction  in  INSTR_W  instruction word.
- ID_out_valid  out  1  decoded instruction available.
- ID_out_ready  in  1  execute accepts.
- ID_opcode  out  OPC_W  decoded opcode.
- ID_parameter1  out  PARAM_W  instruction bits [INSTR_W-OPC_W-1 : PARAM_W].
- ID_parameter2  out  PARAM_W  instruction bits [PARAM_W-1 : 0].
- ID_op_onehot  out  NUM_OPS  one-hot of ID_opcode; all-zero when illegal.
- ID_illegal  out  1  current output carries an illegal opcode.
- ID_trap  out  1  sticky illegal-opcode status.
- ID_trap_clr  in  1  clears ID_trap.

## Operation
- Field decode is combinational on ID_instruction. Decoded fields are stored, not raw words.
- Legal means opcode < NUM_OPS.
- Buffer states:
  - EMPTY: no entries.
  - ONE: output register valid.
  - FULL: output register valid and skid entry valid.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- State transitions:
  - EMPTY: push → ONE.
  - ONE: push & !pop → FULL; pop & !push → EMPTY; push & pop → ONE, output register loads the new entry.
  - FULL: pop → ONE, skid entry moves to the output register.
- No push in FULL, because ID_in_ready=0 there.
- ID_in_ready = (state != FULL), registered from next-state.
- Output fields change only on a pop or on a load into EMPTY. They are stable while ID_out_valid=1 and ID_out_ready=0.
- ID_flush: next state EMPTY, any push that cycle is discarded, and flush has priority. ID_in_ready is 1 the following cycle.
- Reset values of all outputs: state EMPTY; ID_in_ready=1; ID_out_valid=0; ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot=0; ID_illegal=0; ID_trap=0.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

## Timing
- Latency: push in cycle N → ID_out_valid in cycle N+1 when previously EMPTY.
- Throughput: one instruction per cycle with ID_out_ready held high.
- ID_in_ready has no combinational path from ID_out_ready.
- ID_trap sets in the cycle after an illegal entry is pushed.
- If ID_trap_clr and a new illegal push occur in the same cycle, set wins.

## Configuration
- ID_ILLEGAL_TRAP_EN defined:
  - An illegal instruction passes through with its raw opcode and parameters.
  - ID_illegal=1 and ID_op_onehot=0 for that instruction.
  - ID_trap is sticky until ID_trap_clr.
- ID_ILLEGAL_TRAP_EN undefined:
  - An illegal instruction is rewritten as NOP: opcode 0, parameters 0, ID_op_onehot bit0=1.
  - ID_illegal and ID_trap are tied 0; ID_trap_clr is ignored.

## Structure
- Package id_pkg holds:
  - opcode constants OP_NOP=0 through OP_12=12;
  - default INSTR_W, OPC_W and NUM_OPS;
  - the buffer state enum (EMPTY, ONE, FULL);
  - a packed struct of decoded fields (opcode, parameter1, parameter2, onehot, illegal).
- Sub-module id_skid_buf: generic two-entry valid/ready skid buffer, parametrised on payload width, that carries the packed struct. The top level holds the field decode and the trap logic.

## Test plan
- Reset, then push 16'h3A5C with ID_out_ready=1 → next cycle ID_out_valid=1, opcode=3, parameter1=6'h29, parameter2=6'h1C, onehot=13'h0008.
- ID_out_ready=0, push 16'h1000, 16'h2000, 16'h4000 on consecutive cycles → ID_in_ready falls after the second push and the third is not accepted. Raising ID_out_ready then yields opcodes 1, 2, and the third once re-presented, in order with no duplicates.
- Push 16'hD123 with ID_ILLEGAL_TRAP_EN defined → opcode=13, ID_illegal=1, onehot=0, ID_trap=1 until ID_trap_clr. Same stimulus with the macro undefined → opcode=0, parameters=0, onehot=13'h0001, ID_trap=0.
- FULL state, assert ID_flush together with ID_in_valid → next cycle ID_out_valid=0, ID_in_ready=1, and the pushed word never appears at the output.
- Stream 100 random legal words with random ID_out_ready → the output sequence equals the input sequence, and every output field is stable while ID_out_ready=0.
- Assert ID_reset_n low mid-stream, between clock edges → outputs drop to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_pkg.sv
`default_nettype none
//============================================================================
// id_pkg : shared opcodes, default widths, buffer states and the decoded-field
//          layout for the id_decode_pipe instruction-decode stage.
// Rev 1.0
//============================================================================
package id_pkg;

  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_NUM_OPS = 13;
  localparam int DEF_PARAM_W = (DEF_INSTR_W - DEF_OPC_W) / 2;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_1   = 4'd1;
  localparam logic [3:0] OP_2   = 4'd2;
  localparam logic [3:0] OP_3   = 4'd3;
  localparam logic [3:0] OP_4   = 4'd4;
  localparam logic [3:0] OP_5   = 4'd5;
  localparam logic [3:0] OP_6   = 4'd6;
  localparam logic [3:0] OP_7   = 4'd7;
  localparam logic [3:0] OP_8   = 4'd8;
  localparam logic [3:0] OP_9   = 4'd9;
  localparam logic [3:0] OP_10  = 4'd10;
  localparam logic [3:0] OP_11  = 4'd11;
  localparam logic [3:0] OP_12  = 4'd12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  // Field order here is the layout every decode-stage payload follows.
  typedef struct packed {
    logic [DEF_OPC_W-1:0]   opcode;
    logic [DEF_PARAM_W-1:0] parameter1;
    logic [DEF_PARAM_W-1:0] parameter2;
    logic [DEF_NUM_OPS-1:0] onehot;
    logic                   illegal;
  } id_fields_t;

endpackage
`default_nettype wire

// File: rtl/id_skid_buf.sv
`default_nettype none
//============================================================================
// id_skid_buf : generic two-entry valid/ready skid buffer with registered
//               in_ready and synchronous flush.
// Rev 1.0
//============================================================================
module id_skid_buf
  import id_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign push        = in_valid_i & in_ready_q;
  assign out_valid_o = (state_q != EMPTY);
  assign pop         = out_valid_o & out_ready_i;
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_q;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            out_d   = in_data_i;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            out_d = in_data_i;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is registered from the next state so it never depends on out_ready_i.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_decode_pipe.sv
`default_nettype none
//============================================================================
// id_decode_pipe : elastic decode stage; splits instruction fields, flags
//                  illegal opcodes and emits a one-hot opcode vector.
// ID_ILLEGAL_TRAP_EN: pass illegal opcodes through and keep a sticky trap;
//                     otherwise illegal words are rewritten as NOP.
// Rev 1.0
//============================================================================
module id_decode_pipe
  import id_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic                           ID_clock,
  input  logic                           ID_reset_n,
  input  logic                           ID_flush,
  input  logic                           ID_in_valid,
  output logic                           ID_in_ready,
  input  logic [INSTR_W-1:0]             ID_instruction,
  output logic                           ID_out_valid,
  input  logic                           ID_out_ready,
  output logic [OPC_W-1:0]               ID_opcode,
  output logic [(INSTR_W-OPC_W)/2-1:0]   ID_parameter1,
  output logic [(INSTR_W-OPC_W)/2-1:0]   ID_parameter2,
  output logic [NUM_OPS-1:0]             ID_op_onehot,
  output logic                           ID_illegal,
  output logic                           ID_trap,
  input  logic                           ID_trap_clr
);

  localparam int PARAM_W = (INSTR_W - OPC_W) / 2;

  // Same layout as id_fields_t, sized by this instance's parameters.
  typedef struct packed {
    logic [OPC_W-1:0]   opcode;
    logic [PARAM_W-1:0] parameter1;
    logic [PARAM_W-1:0] parameter2;
    logic [NUM_OPS-1:0] onehot;
    logic               illegal;
  } dec_t;

  logic [OPC_W-1:0]   raw_opc;
  logic [PARAM_W-1:0] raw_p1;
  logic [PARAM_W-1:0] raw_p2;
  logic               legal;
  dec_t               dec;
  dec_t               out;

  assign raw_opc = ID_instruction[INSTR_W-1 -: OPC_W];
  assign raw_p1  = ID_instruction[INSTR_W-OPC_W-1 -: PARAM_W];
  assign raw_p2  = ID_instruction[PARAM_W-1:0];
  assign legal   = 32'(raw_opc) < 32'(NUM_OPS);

  always_comb begin
    dec            = '0;
    dec.opcode     = raw_opc;
    dec.parameter1 = raw_p1;
    dec.parameter2 = raw_p2;
    for (int i = 0; i < NUM_OPS; i++) begin
      dec.onehot[i] = legal && (32'(raw_opc) == 32'(i));
    end
`ifdef ID_ILLEGAL_TRAP_EN
    dec.illegal = !legal;
`else
    if (!legal) begin
      dec.opcode     = OPC_W'(OP_NOP);
      dec.parameter1 = '0;
      dec.parameter2 = '0;
      dec.onehot[0]  = 1'b1;
    end
`endif
  end

  id_skid_buf #(
    .DATA_W ($bits(dec_t))
  ) u_skid (
    .clk_i       (ID_clock),
    .rst_ni      (ID_reset_n),
    .flush_i     (ID_flush),
    .in_valid_i  (ID_in_valid),
    .in_ready_o  (ID_in_ready),
    .in_data_i   (dec),
    .out_valid_o (ID_out_valid),
    .out_ready_i (ID_out_ready),
    .out_data_o  (out)
  );

  assign ID_opcode     = out.opcode;
  assign ID_parameter1 = out.parameter1;
  assign ID_parameter2 = out.parameter2;
  assign ID_op_onehot  = out.onehot;
  assign ID_illegal    = ID_out_valid & out.illegal;

`ifdef ID_ILLEGAL_TRAP_EN
  logic push;
  logic trap_q, trap_d;

  // A push discarded by flush never reaches execute, so it cannot trap.
  assign push = ID_in_valid & ID_in_ready & ~ID_flush;

  always_comb begin
    trap_d = trap_q;
    if (ID_trap_clr) trap_d = 1'b0;
    if (push && dec.illegal) trap_d = 1'b1;
  end

  always_ff @(posedge ID_clock or negedge ID_reset_n) begin
    if (!ID_reset_n) trap_q <= 1'b0;
    else             trap_q <= trap_d;
  end

  assign ID_trap = trap_q;
`else
  logic unused_trap_clr;
  assign unused_trap_clr = ID_trap_clr;
  assign ID_trap         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_decode_pipe.sv
`default_nettype none
// Self-checking bench for id_decode_pipe: scoreboard of expected decodes,
// pushed on accepted input and compared on each output handshake.
module tb_id_decode_pipe;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  opc;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [12:0] oh;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        ID_flush;
  logic        ID_in_valid;
  logic        ID_in_ready;
  logic [15:0] ID_instruction;
  logic        ID_out_valid;
  logic        ID_out_ready;
  logic [3:0]  ID_opcode;
  logic [5:0]  ID_parameter1;
  logic [5:0]  ID_parameter2;
  logic [12:0] ID_op_onehot;
  logic        ID_illegal;
  logic        ID_trap;
  logic        ID_trap_clr;

  exp_t sb[$];
  bit   hold_v;
  exp_t hold_f;
  int   n_cmp;
  int   n_err;
  int   n_pop;

  id_decode_pipe dut (
    .ID_clock       (clk),
    .ID_reset_n     (rst_n),
    .ID_flush       (ID_flush),
    .ID_in_valid    (ID_in_valid),
    .ID_in_ready    (ID_in_ready),
    .ID_instruction (ID_instruction),
    .ID_out_valid   (ID_out_valid),
    .ID_out_ready   (ID_out_ready),
    .ID_opcode      (ID_opcode),
    .ID_parameter1  (ID_parameter1),
    .ID_parameter2  (ID_parameter2),
    .ID_op_onehot   (ID_op_onehot),
    .ID_illegal     (ID_illegal),
    .ID_trap        (ID_trap),
    .ID_trap_clr    (ID_trap_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [15:0] w);
    exp_t e;
    int   o;
    o = int'(w[15:12]);
    if (o < 13) begin
      e = '{opc: w[15:12], p1: w[11:6], p2: w[5:0], oh: 13'(1) << o, ill: 1'b0};
    end else if (TRAP_EN) begin
      e = '{opc: w[15:12], p1: w[11:6], p2: w[5:0], oh: 13'h0, ill: 1'b1};
    end else begin
      e = '{opc: 4'h0, p1: 6'h0, p2: 6'h0, oh: 13'h1, ill: 1'b0};
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_legal();
    return {4'($urandom_range(0, 12)), 12'($urandom)};
  endfunction

  // Observes handshakes at the negedge before the capturing posedge, then advances.
  task automatic tick();
    exp_t got;
    exp_t e;
    got = {ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal};
    if (hold_v && ID_out_valid) begin
      n_cmp++;
      if (got !== hold_f) begin
        n_err++;
        $display("FAIL stable: got %h want %h", got, hold_f);
      end
    end
    if (ID_flush) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      if (ID_in_valid && ID_in_ready) sb.push_back(model(ID_instruction));
      if (ID_out_valid && ID_out_ready) begin
        n_cmp++;
        n_pop++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got %h want none", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL scoreboard: got %h want %h", got, e);
          end
        end
      end
      hold_v = ID_out_valid && !ID_out_ready;
      hold_f = got;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ID_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", ID_in_ready); end
    n_cmp++;
    if (ID_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", ID_out_valid); end
    n_cmp++;
    if ({ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal} !== 30'h0) begin
      n_err++;
      $display("FAIL reset_fields: got %h want 0", {ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal});
    end
    n_cmp++;
    if (ID_trap !== 1'b0) begin n_err++; $display("FAIL reset_trap: got %b want 0", ID_trap); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    ID_out_ready   = 1'b1;
    ID_instruction = 16'h3A5C;
    ID_in_valid    = 1'b1;
    tick();
    ID_in_valid = 1'b0;
    n_cmp++;
    if (ID_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency: got %b want 1", ID_out_valid); end
    n_cmp++;
    if ({ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot} !== {4'd3, 6'h29, 6'h1C, 13'h0008}) begin
      n_err++;
      $display("FAIL basic_fields: got %h want %h", {ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot},
               {4'd3, 6'h29, 6'h1C, 13'h0008});
    end
    tick();
    n_cmp++;
    if (ID_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", ID_out_valid); end
  endtask

  task automatic test_back_to_back();
    int  p0;
    int  cyc;
    bit  acc;
    p0 = n_pop;
    ID_out_ready   = 1'b0;
    ID_in_valid    = 1'b1;
    ID_instruction = 16'h1000;
    tick();
    ID_instruction = 16'h2000;
    n_cmp++;
    if (ID_in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_one: got %b want 1", ID_in_ready); end
    tick();
    ID_instruction = 16'h4000;
    n_cmp++;
    if (ID_in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b want 0", ID_in_ready); end
    tick();
    n_cmp++;
    if ({ID_in_ready, ID_opcode} !== {1'b0, 4'd1}) begin
      n_err++;
      $display("FAIL b2b_stall: got %h want %h", {ID_in_ready, ID_opcode}, {1'b0, 4'd1});
    end
    ID_out_ready = 1'b1;
    cyc = 0;
    while ((ID_in_valid || sb.size() != 0) && cyc < 20) begin
      acc = ID_in_valid && ID_in_ready;
      tick();
      cyc++;
      if (acc) ID_in_valid = 1'b0;
    end
    n_cmp++;
    if (n_pop - p0 !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", n_pop - p0); end
    n_cmp++;
    if (ID_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_empty: got %b want 0", ID_out_valid); end
  endtask

  task automatic test_illegal();
    exp_t want;
    want = TRAP_EN ? exp_t'({4'hD, 6'h04, 6'h23, 13'h0, 1'b1}) : exp_t'({4'h0, 6'h0, 6'h0, 13'h1, 1'b0});
    ID_out_ready   = 1'b1;
    ID_instruction = 16'hD123;
    ID_in_valid    = 1'b1;
    tick();
    ID_in_valid = 1'b0;
    n_cmp++;
    if ({ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal} !== want) begin
      n_err++;
      $display("FAIL illegal_fields: got %h want %h",
               {ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal}, want);
    end
    n_cmp++;
    if (ID_trap !== TRAP_EN) begin n_err++; $display("FAIL trap_set: got %b want %b", ID_trap, TRAP_EN); end
    repeat (3) tick();
    n_cmp++;
    if (ID_trap !== TRAP_EN) begin n_err++; $display("FAIL trap_sticky: got %b want %b", ID_trap, TRAP_EN); end
    ID_trap_clr = 1'b1;
    tick();
    ID_trap_clr = 1'b0;
    n_cmp++;
    if (ID_trap !== 1'b0) begin n_err++; $display("FAIL trap_clr: got %b want 0", ID_trap); end
    ID_trap_clr = 1'b1;
    ID_in_valid = 1'b1;
    tick();
    ID_trap_clr = 1'b0;
    ID_in_valid = 1'b0;
    n_cmp++;
    if (ID_trap !== TRAP_EN) begin n_err++; $display("FAIL trap_set_wins: got %b want %b", ID_trap, TRAP_EN); end
    tick();
    ID_trap_clr = 1'b1;
    tick();
    ID_trap_clr = 1'b0;
  endtask

  task automatic test_flush();
    ID_out_ready   = 1'b0;
    ID_in_valid    = 1'b1;
    ID_instruction = 16'h1111;
    tick();
    ID_instruction = 16'h2222;
    tick();
    ID_instruction = 16'h5ABC;
    ID_flush       = 1'b1;
    tick();
    ID_flush    = 1'b0;
    ID_in_valid = 1'b0;
    n_cmp++;
    if ({ID_out_valid, ID_in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_full: got %b want 01", {ID_out_valid, ID_in_ready});
    end
    ID_in_valid    = 1'b1;
    ID_instruction = 16'h3333;
    tick();
    ID_instruction = 16'h6DEF;
    ID_flush       = 1'b1;
    tick();
    ID_flush     = 1'b0;
    ID_in_valid  = 1'b0;
    n_cmp++;
    if ({ID_out_valid, ID_in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL flush_one: got %b want 01", {ID_out_valid, ID_in_ready});
    end
    ID_out_ready = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (ID_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got %b want 0", ID_out_valid); end
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    int p0;
    bit acc;
    sent = 0;
    cyc  = 0;
    p0   = n_pop;
    ID_instruction = rand_legal();
    ID_in_valid    = 1'b1;
    while ((sent < 100 || sb.size() != 0 || ID_out_valid) && cyc < 1500) begin
      ID_out_ready = 1'($urandom_range(0, 1));
      acc = ID_in_valid && ID_in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 100) ID_instruction = rand_legal();
        else            ID_in_valid = 1'b0;
      end
    end
    ID_in_valid  = 1'b0;
    ID_out_ready = 1'b0;
    n_cmp++;
    if (cyc >= 1500) begin n_err++; $display("FAIL random_timeout: got %0d cycles want <1500", cyc); end
    n_cmp++;
    if (n_pop - p0 !== 100) begin n_err++; $display("FAIL random_count: got %0d want 100", n_pop - p0); end
  endtask

  task automatic test_async_reset();
    ID_out_ready   = 1'b0;
    ID_in_valid    = 1'b1;
    ID_instruction = 16'h7ABC;
    tick();
    ID_instruction = 16'hE000;
    tick();
    ID_in_valid = 1'b0;
    n_cmp++;
    if ({ID_out_valid, ID_opcode} !== {1'b1, 4'd7}) begin
      n_err++;
      $display("FAIL areset_pre: got %h want %h", {ID_out_valid, ID_opcode}, {1'b1, 4'd7});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ID_out_valid, ID_in_ready, ID_trap} !== 3'b010) begin
      n_err++;
      $display("FAIL areset_ctrl: got %b want 010", {ID_out_valid, ID_in_ready, ID_trap});
    end
    n_cmp++;
    if ({ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal} !== 30'h0) begin
      n_err++;
      $display("FAIL areset_fields: got %h want 0", {ID_opcode, ID_parameter1, ID_parameter2, ID_op_onehot, ID_illegal});
    end
    sb.delete();
    hold_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    n_pop          = 0;
    hold_v         = 1'b0;
    hold_f         = '0;
    rst_n          = 1'b0;
    ID_flush       = 1'b0;
    ID_in_valid    = 1'b0;
    ID_instruction = 16'h0;
    ID_out_ready   = 1'b0;
    ID_trap_clr    = 1'b0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_random();
    test_async_reset();

    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d want 0", sb.size()); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
